// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Multiplexed 7-segment scan controller for the board's LED digits, running
// on the divided 1 kHz display clock.
//
// Features: configurable digit count, PWM brightness, per-digit decimal
// points, per-digit blink, leading-zero suppression and a raw-segment mode.
// Display data is double-buffered. New data is swapped in only at frame
// boundaries, so a single frame never mixes old and new digits.
//
// Scan order: each digit owns 2^BRIGHT_W consecutive PWM slots. Digits are
// visited in order 0..DIGITS-1. One frame is DIGITS*2^BRIGHT_W cycles.
//
// Ports
//   clk_1k      in   display scan clock
//   rstn        in   asynchronous active-low reset
//   load        in   single-cycle strobe; captures data/raw/dp into pending
//   data        in   hex nibbles, digit k = data[4k+3:4k]
//   raw         in   raw active-low segment bytes, digit k = raw[8k+7:8k]
//   dp          in   decimal point enable per digit (hex mode)
//   raw_mode    in   0 = hex decode, 1 = raw bytes (live)
//   blank_lz    in   suppress leading zeros in hex mode (live)
//   blink_mask  in   digits that blink (live)
//   bright      in   brightness; digit lit in slots s <= bright (live)
//   seg         out  active-low segments, bit7 = DP (registered)
//   sel         out  active-low one-hot digit enable (registered)
//   frame_done  out  one-cycle pulse on the last slot of each frame
//
// Handshake: load is a plain strobe with no backpressure. Every cycle in
// which load is high overwrites the pending buffer, so the last load before
// a frame boundary wins.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int BRIGHT_W  = 3,
  parameter int BLINK_DIV = 500
) (
  input  logic                  clk_1k,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [8*DIGITS-1:0]   raw,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  raw_mode,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int KW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [BRIGHT_W-1:0]  slot;        // PWM slot within the current digit
  logic [KW-1:0]        dig;         // digit currently being scanned
  logic [BCW-1:0]       blink_cnt;   // free-running blink divider
  logic                 blink_phase; // 1 = blinking digits are dark

  logic [4*DIGITS-1:0]  act_data;
  logic [8*DIGITS-1:0]  act_raw;
  logic [DIGITS-1:0]    act_dp;
  logic [4*DIGITS-1:0]  pend_data;
  logic [8*DIGITS-1:0]  pend_raw;
  logic [DIGITS-1:0]    pend_dp;
  logic                 pend_valid;

  // ---------------------------------------------------------------------------
  // Active-low hex decode, bit7 (DP) left off
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] r;
    case (nib)
      4'h0: r = 8'hC0;
      4'h1: r = 8'hF9;
      4'h2: r = 8'hA4;
      4'h3: r = 8'hB0;
      4'h4: r = 8'h99;
      4'h5: r = 8'h92;
      4'h6: r = 8'h82;
      4'h7: r = 8'hF8;
      4'h8: r = 8'h80;
      4'h9: r = 8'h90;
      4'hA: r = 8'h88;
      4'hB: r = 8'h83;
      4'hC: r = 8'hC6;
      4'hD: r = 8'hA1;
      4'hE: r = 8'h86;
      default: r = 8'h8E;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Buffer swap
  //
  // The swap happens at the edge that ends the frame_done cycle. That same
  // edge also registers slot 0 of digit 0 of the new frame. The display path
  // therefore looks through to the pending buffer while swapping, so the
  // first slot of the new frame already shows the new data.
  // ---------------------------------------------------------------------------
  logic                 swap;
  logic [4*DIGITS-1:0]  cur_data;
  logic [8*DIGITS-1:0]  cur_raw_vec;
  logic [DIGITS-1:0]    cur_dp;

  assign swap        = frame_done & pend_valid;
  assign cur_data    = swap ? pend_data : act_data;
  assign cur_raw_vec = swap ? pend_raw  : act_raw;
  assign cur_dp      = swap ? pend_dp   : act_dp;

  // ---------------------------------------------------------------------------
  // Per-digit selection
  //
  // zero_run walks from the top digit downward. It stays 1 while every
  // nibble seen so far is zero. When the walk reaches the current digit,
  // zero_run tells whether that digit is a leading zero.
  // ---------------------------------------------------------------------------
  logic [3:0] cur_nib;
  logic [7:0] cur_raw;
  logic       cur_dp_k;
  logic       cur_blink;
  logic       cur_lz;
  logic       zero_run;

  always_comb begin
    cur_nib   = 4'h0;
    cur_raw   = 8'hFF;
    cur_dp_k  = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (cur_data[4*i +: 4] == 4'h0);
      if (dig == KW'(i)) begin
        cur_nib   = cur_data[4*i +: 4];
        cur_raw   = cur_raw_vec[8*i +: 8];
        cur_dp_k  = cur_dp[i];
        cur_blink = blink_mask[i];
        cur_lz    = zero_run;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot visibility and segment pattern
  // ---------------------------------------------------------------------------
  logic       pwm_on;
  logic       blink_blank;
  logic       lz_blank;
  logic       lit;
  logic [7:0] seg_val;
  logic       last_slot;

  assign pwm_on      = (slot <= bright);
  assign blink_blank = blink_phase & cur_blink;

  // Digit 0 always shows, so all-zero data displays a single "0".
  // A digit with its DP set is exempt from suppression.
  assign lz_blank    = ~raw_mode & blank_lz & (dig != '0) & ~cur_dp_k & cur_lz;
  assign lit         = pwm_on & ~blink_blank & ~lz_blank;

  assign seg_val     = raw_mode ? cur_raw
                                : (hex7(cur_nib) & {~cur_dp_k, 7'h7F});

  assign last_slot   = (slot == '1) && (dig == KW'(DIGITS - 1));

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_1k or negedge rstn) begin
    if (!rstn) begin
      slot        <= '0;
      dig         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      act_data    <= '0;
      act_raw     <= '0;
      act_dp      <= '0;
      pend_data   <= '0;
      pend_raw    <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      seg         <= 8'hFF;
      sel         <= '1;
      frame_done  <= 1'b0;
    end else begin
      // Scan position: slot advances every cycle; digit advances on slot wrap.
      slot <= slot + 1'b1;
      if (slot == '1) begin
        if (dig == KW'(DIGITS - 1)) dig <= '0;
        else                        dig <= dig + 1'b1;
      end

      // Blink divider: phase toggles every BLINK_DIV cycles.
      if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end

      // Double buffer. A load on the swap edge lands in pending after the
      // old pending has moved to active, so it shows one frame later.
      if (swap) begin
        act_data <= pend_data;
        act_raw  <= pend_raw;
        act_dp   <= pend_dp;
      end
      if (load) begin
        pend_data  <= data;
        pend_raw   <= raw;
        pend_dp    <= dp;
        pend_valid <= 1'b1;
      end else if (swap) begin
        pend_valid <= 1'b0;
      end

      // Registered display outputs for the current scan position.
      if (lit) begin
        seg <= seg_val;
        sel <= ~(DIGITS'(1) << dig);
      end else begin
        seg <= 8'hFF;
        sel <= '1;
      end
      frame_done <= last_slot;
    end
  end

endmodule
